// File: rtl/sipo_deser.sv
// sipo_deser: serial-in parallel-out deserializer.
// Serial bits qualified by ce & sin_valid are assembled into WIDTH-bit words.
// A sync bit restarts the word. Completed words go into a one-word holding
// register with a valid/ready handshake. A sticky overrun flag records a
// completed word that had to be dropped.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   ce                    serial-side clock enable
//   sin_valid, sin, sync  serial bit, its qualifier, and the word-start marker
//   clr_overrun           synchronous clear of overrun
//   out_data, out_valid   holding register and its valid flag
//   out_ready             consumer accept
//   overrun               sticky drop flag
//   busy, bit_cnt         partial word in progress / bits accepted so far
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic                       sin_valid,
  input  logic                       sin,
  input  logic                       sync,
  input  logic                       clr_overrun,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overrun,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             accept;
  logic             complete;
  logic [WIDTH-1:0] sr_shift;
  logic [WIDTH-1:0] sr_first;

  assign accept = ce & sin_valid;

  always_comb begin
    if (MSB_FIRST) begin
      sr_shift = {sr_q[WIDTH-2:0], sin};
      sr_first = {{(WIDTH-1){1'b0}}, sin};
    end else begin
      sr_shift = {sin, sr_q[WIDTH-1:1]};
      sr_first = {sin, {(WIDTH-1){1'b0}}};
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          state_d = SHIFT;
          sr_d    = sr_first;
          cnt_d   = CW'(1);
        end
        default: begin
          if (sync) begin
            // Sync wins over completion: the partial word is discarded.
            sr_d  = sr_first;
            cnt_d = CW'(1);
          end else if (cnt_q == CW'(WIDTH - 1)) begin
            complete = 1'b1;
            state_d  = IDLE;
            sr_d     = sr_shift;
            cnt_d    = '0;
          end else begin
            sr_d  = sr_shift;
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (clr_overrun) ovr_d = 1'b0;
    if (complete) begin
      // A pop on the same edge frees the holding register for the new word.
      if (!valid_q || out_ready) begin
        data_d  = sr_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q == SHIFT);
  assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: directed self-checking bench for sipo_deser.
// Two instances share the serial inputs: dut_m (MSB first) and dut_l (LSB first).
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0;
  logic       sin_valid = 1'b0;
  logic       sin = 1'b0;
  logic       sync = 1'b0;
  logic       clr_overrun = 1'b0;
  logic       out_ready = 1'b1;

  logic [7:0] data_m, data_l;
  logic       valid_m, valid_l;
  logic       ovr_m, ovr_l;
  logic       busy_m, busy_l;
  logic [3:0] cnt_m, cnt_l;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .ce(ce), .sin_valid(sin_valid), .sin(sin),
    .sync(sync), .clr_overrun(clr_overrun), .out_data(data_m),
    .out_valid(valid_m), .out_ready(out_ready), .overrun(ovr_m),
    .busy(busy_m), .bit_cnt(cnt_m)
  );

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .ce(ce), .sin_valid(sin_valid), .sin(sin),
    .sync(sync), .clr_overrun(clr_overrun), .out_data(data_l),
    .out_valid(valid_l), .out_ready(out_ready), .overrun(ovr_l),
    .busy(busy_l), .bit_cnt(cnt_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with an accepted bit; outputs are sampled 1 time unit after the edge.
  task automatic send_bit(input logic b, input logic s);
    ce = 1'b1; sin_valid = 1'b1; sin = b; sync = s;
    @(posedge clk); #1;
    ce = 1'b0; sin_valid = 1'b0; sync = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // Sends w MSB first, optionally with sync on the first bit.
  task automatic send_word(input logic [7:0] w, input logic s_first);
    for (int i = 7; i >= 0; i--) send_bit(w[i], (i == 7) && s_first);
  endtask

  logic [7:0] w;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", valid_m, 0);
    check("rst_data", data_m, 0);
    check("rst_busy", busy_m, 0);
    check("rst_cnt", cnt_m, 0);
    check("rst_ovr", ovr_m, 0);
    check("rst_valid_l", valid_l, 0);
    rst = 1'b0;
    idle_cycle();

    // 1 & 2: 1,1,0,0,0,0,0,1 -> 0xC1 MSB first, 0x83 LSB first
    out_ready = 1'b1;
    send_word(8'hC1, 1'b1);
    check("t1_valid", valid_m, 1);
    check("t1_data", data_m, 8'hC1);
    check("t1_busy", busy_m, 0);
    check("t1_cnt", cnt_m, 0);
    check("t2_valid_l", valid_l, 1);
    check("t2_data_l", data_l, 8'h83);
    idle_cycle();
    check("t1_valid_pulse", valid_m, 0);
    check("t1_ovr", ovr_m, 0);
    check("t1_data_hold", data_m, 8'hC1);
    check("t2_ovr_l", ovr_l, 0);

    // 3: 0xA5 with ce=0 and sin_valid=0 gaps between bits
    w = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i], i == 7);
      if (i > 0) begin
        ce = 1'b0; sin_valid = 1'b1; sin = ~w[i];
        @(posedge clk); #1;
        check("t3_cnt_ce0", cnt_m, 8 - i);
        check("t3_busy_ce0", busy_m, 1);
        ce = 1'b1; sin_valid = 1'b0;
        @(posedge clk); #1;
        ce = 1'b0;
        check("t3_cnt_nv", cnt_m, 8 - i);
        check("t3_valid_nv", valid_m, 0);
      end
    end
    check("t3_data", data_m, 8'hA5);
    check("t3_valid", valid_m, 1);
    idle_cycle();

    // 4: 5 bits, then sync on word 0x3C
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    check("t4_cnt5", cnt_m, 5);
    w = 8'h3C;
    send_bit(w[7], 1'b1);
    check("t4_cnt_sync", cnt_m, 1);
    check("t4_busy_sync", busy_m, 1);
    for (int i = 6; i >= 0; i--) begin
      send_bit(w[i], 1'b0);
      if (i > 0) check("t4_no_early", valid_m, 0);
    end
    check("t4_data", data_m, 8'h3C);
    check("t4_valid", valid_m, 1);
    idle_cycle();
    // sync when bit_cnt = 7: old partial word never completes
    for (int i = 0; i < 7; i++) send_bit(1'b1, i == 0);
    check("t4b_cnt7", cnt_m, 7);
    w = 8'h96;
    send_bit(w[7], 1'b1);
    check("t4b_no_complete", valid_m, 0);
    check("t4b_cnt1", cnt_m, 1);
    for (int i = 6; i >= 0; i--) send_bit(w[i], 1'b0);
    check("t4b_data", data_m, 8'h96);
    idle_cycle();

    // 5: overrun with out_ready=0
    out_ready = 1'b0;
    send_word(8'h11, 1'b1);
    check("t5_valid11", valid_m, 1);
    check("t5_data11", data_m, 8'h11);
    send_word(8'h22, 1'b1);
    check("t5_data_kept", data_m, 8'h11);
    check("t5_ovr_set", ovr_m, 1);
    check("t5_valid_kept", valid_m, 1);
    idle_cycle();
    check("t5_ovr_sticky", ovr_m, 1);
    clr_overrun = 1'b1;
    idle_cycle();
    clr_overrun = 1'b0;
    check("t5_ovr_clr", ovr_m, 0);
    out_ready = 1'b1;
    idle_cycle();
    check("t5_popped", valid_m, 0);
    // ready asserted on the completion edge: no bubble, no overrun
    out_ready = 1'b0;
    send_word(8'h11, 1'b1);
    w = 8'h22;
    for (int i = 7; i >= 1; i--) send_bit(w[i], i == 7);
    check("t5b_data11", data_m, 8'h11);
    out_ready = 1'b1;
    send_bit(w[0], 1'b0);
    check("t5b_data22", data_m, 8'h22);
    check("t5b_valid", valid_m, 1);
    check("t5b_ovr", ovr_m, 0);
    idle_cycle();
    check("t5b_popped", valid_m, 0);
    // set and clear on the same edge: set wins
    out_ready = 1'b0;
    send_word(8'h11, 1'b1);
    w = 8'h22;
    for (int i = 7; i >= 1; i--) send_bit(w[i], i == 7);
    clr_overrun = 1'b1;
    send_bit(w[0], 1'b0);
    clr_overrun = 1'b0;
    check("t5c_set_wins", ovr_m, 1);
    check("t5c_data", data_m, 8'h11);

    // 6: asynchronous reset mid-word and with a pending word
    for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
    check("t6_cnt4", cnt_m, 4);
    #2 rst = 1'b1;
    #1;
    check("t6a_busy", busy_m, 0);
    check("t6a_cnt", cnt_m, 0);
    check("t6a_valid", valid_m, 0);
    check("t6a_ovr", ovr_m, 0);
    check("t6a_data", data_m, 0);
    #1 rst = 1'b0;
    out_ready = 1'b0;
    send_word(8'hE7, 1'b1);
    check("t6_pending", valid_m, 1);
    #2 rst = 1'b1;
    #1;
    check("t6b_valid", valid_m, 0);
    check("t6b_data", data_m, 0);
    check("t6b_busy", busy_m, 0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    send_word(8'h5A, 1'b1);
    check("t6_data5A", data_m, 8'h5A);
    check("t6_valid5A", valid_m, 1);
    check("t6_ovr5A", ovr_m, 0);
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
Serial-in parallel-out deserializer. It is the receiving end of the bit-serial link whose transmit side is fed from the parallel data registers. Serial bits arrive with a valid qualifier and a frame-sync marker, are assembled into WIDTH-bit words, and are presented on a valid/ready parallel output with a one-word holding register and a sticky overrun flag.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 means the first received bit lands in bit WIDTH-1; 0 means the first bit lands in bit 0.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous reset, active-high.
ce  in  1  clock enable for the serial side only.
sin_valid  in  1  sin carries a bit this cycle.
sin  in  1  serial data bit.
sync  in  1  marks the accepted bit as the first bit of a new word; qualified by ce and sin_valid.
clr_overrun  in  1  synchronous clear of overrun.
out_data  out  WIDTH  assembled word; stable while out_valid is 1.
out_valid  out  1  out_data holds an unconsumed word.
out_ready  in  1  consumer accepts out_data when out_valid and out_ready are both 1.
overrun  out  1  sticky flag; a completed word was dropped.
busy  out  1  a partial word is in progress (state SHIFT).
bit_cnt  out  $clog2(WIDTH+1)  number of bits already accepted into the current word.

Behaviour:
- Reset: all outputs 0, shift register 0, state IDLE. Asynchronous assertion, and it aborts any partial word or pending output word.
- An accepted bit is a cycle with ce=1 and sin_valid=1. Cycles with ce=0 freeze shift register, bit_cnt and state. ce does not gate the output handshake or clr_overrun.
- Shift: when MSB_FIRST=1, sr <= {sr[WIDTH-2:0], sin}. When MSB_FIRST=0, sr <= {sin, sr[WIDTH-1:1]}.
- FSM IDLE: bit_cnt=0, busy=0. An accepted bit moves to SHIFT with bit_cnt=1, whether sync is 0 or 1.
- FSM SHIFT: each accepted bit increments bit_cnt.
- Sync in SHIFT: an accepted bit with sync=1 discards the partial word. The shift register restarts with this bit as bit one, bit_cnt=1, and the state stays SHIFT. This applies even when bit_cnt=WIDTH-1; the old partial word never completes. sync=1 without an accepted bit is ignored.
- Completion: occurs when an accepted bit has sync=0 and bit_cnt=WIDTH-1. On that edge the full word, including the current bit, goes to the holding register, the state returns to IDLE and bit_cnt becomes 0.
- Latency: out_valid=1 and out_data are valid in the cycle after the edge that captured the last bit.
- Handshake: out_valid clears on the edge where out_valid=1 and out_ready=1, unless a completion also occurs on that edge. In that case the new word loads and out_valid stays 1 with no bubble and no overrun.
- Overrun: completion while out_valid=1 and out_ready=0 drops the new word. The holding register keeps the old word and overrun is set to 1. overrun stays set until clr_overrun=1. If set and clear happen on the same edge, set wins.
- out_data holds its last value after consumption; it is not zeroed.
- Arithmetic: bit_cnt never exceeds WIDTH-1 while visible. It is unsigned and has no wrap-around, because completion always resets it.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, out_ready=1. Stream 1,1,0,0,0,0,0,1 on consecutive cycles, sync on the first bit -> out_valid=1 one cycle after the 8th bit, out_data=0xC1. out_valid is 1 for exactly one cycle and overrun stays 0.
2. Same stream with MSB_FIRST=0 -> out_data=0x83.
3. Interleave ce=0 and sin_valid=0 gaps between every bit of 0xA5 -> out_data=0xA5. bit_cnt holds across the gaps and busy=1 throughout.
4. Send 5 bits, then assert sync on a new word 0x3C -> the partial word is discarded, a single word 0x3C is produced and bit_cnt shows 1 after the sync bit.
5. out_ready=0. Send 0x11 then 0x22 -> out_data stays 0x11 and overrun=1 after the 0x22 completion. Pulsing clr_overrun clears overrun. With out_ready=1 at the 0x22 completion edge instead, out_data=0x22, out_valid stays 1 and overrun stays 0.
6. Assert rst asynchronously mid-word (bit_cnt=4) and again while out_valid=1 -> immediately out_valid=0, busy=0, bit_cnt=0, overrun=0, out_data=0. A following full word 0x5A is received correctly.
